dfp_arbiter: RTL

Shares the single 256-bit cacheline memory port between several caches (I-cache, D-cache) that each drive their own downward-facing port (dfp). Each requester issues one whole-line read or write and holds it until it sees a response. The arbiter grants one requester at a time in round-robin order and forwards that requester's transaction to memory through registered outputs. It routes the memory response back to the owner only. It sits between the cache instances and the memory model/bus adapter.

---
 rtl/cache_types_pkg.sv | 31 +++
 rtl/rr_picker.sv | 38 +++
 rtl/dfp_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_types_pkg
// Description : Shared types for the cache-to-memory dfp arbitration path.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_types_pkg;

   localparam int LINE_BITS   = 256;
   localparam int c_ADDR_BITS = 32;

   typedef struct packed {
      logic [c_ADDR_BITS-1:0] addr;
      logic                   read;
      logic                   write;
      logic [LINE_BITS-1:0]   wdata;
   } dfp_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // Index width that stays legal for a single-port build.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker; first pending port after
//               last_grant, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
   import cache_types_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = idx_bits(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] pending,
   input  logic [IDX_W-1:0]     last_grant,
   output logic                 grant_valid,
   output logic [IDX_W-1:0]     grant_idx
);

   logic [IDX_W-1:0] w_cand;

   // Walk from the farthest candidate (last_grant itself) to the nearest so
   // the closest pending port after last_grant is the final assignment.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      w_cand      = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         w_cand = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
         if (pending[w_cand]) begin
            grant_valid = 1'b1;
            grant_idx   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dfp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dfp_arbiter
// Description : Round-robin arbiter sharing one cacheline memory port among
//               several cache dfp ports, with registered memory outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dfp_arbiter
   import cache_types_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            req_addr  [NUM_PORTS],
   input  logic [NUM_PORTS-1:0]   req_read,
   input  logic [NUM_PORTS-1:0]   req_write,
   input  logic [LINE_BITS-1:0]   req_wdata [NUM_PORTS],
   output logic [LINE_BITS-1:0]   req_rdata [NUM_PORTS],
   output logic [NUM_PORTS-1:0]   req_resp,
   output logic [31:0]            mem_addr,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [LINE_BITS-1:0]   mem_wdata,
   input  logic [LINE_BITS-1:0]   mem_rdata,
   input  logic                   mem_resp
);

   localparam int                 c_IDX_W     = idx_bits(NUM_PORTS);
   localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(NUM_PORTS - 1);

   arb_state_t         r_state;
   arb_state_t         w_next_state;
   logic [c_IDX_W-1:0] r_owner;
   logic [c_IDX_W-1:0] r_last_grant;
   logic [c_IDX_W-1:0] w_grant_idx;
   logic               w_grant_valid;
   logic               w_launch;
   logic               w_active;
   dfp_req_t           w_sel;

   rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (c_IDX_W)
   ) u_picker (
      .pending     (req_read | req_write),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant_idx   (w_grant_idx)
   );

   // A port asserting both read and write is issued as a write.
   always_comb begin
      w_sel       = '0;
      w_sel.addr  = req_addr[w_grant_idx];
      w_sel.write = req_write[w_grant_idx];
      w_sel.read  = req_read[w_grant_idx] & ~req_write[w_grant_idx];
      w_sel.wdata = req_wdata[w_grant_idx];
   end

   always_comb begin
      w_next_state = r_state;
      w_launch     = 1'b0;
      w_active     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_next_state = ISSUE;
               w_launch     = 1'b1;
            end
         end
         ISSUE: begin
            w_active     = 1'b1;
            w_next_state = mem_resp ? IDLE : WAIT;
         end
         WAIT: begin
            w_active = 1'b1;
            if (mem_resp) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Address and data stay on the bus after completion; only the strobes drop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr     <= '0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         mem_wdata    <= '0;
         r_owner      <= '0;
         r_last_grant <= c_LAST_INIT;
      end else if (w_launch) begin
         mem_addr     <= w_sel.addr;
         mem_read     <= w_sel.read;
         mem_write    <= w_sel.write;
         mem_wdata    <= w_sel.wdata;
         r_owner      <= w_grant_idx;
         r_last_grant <= w_grant_idx;
      end else if (w_active && mem_resp) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   generate
      for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
         assign req_resp[i]  = w_active & mem_resp & (r_owner == c_IDX_W'(i));
         assign req_rdata[i] = mem_rdata;
      end
   endgenerate

endmodule
`default_nettype wire
